player_hit_ctl: RTL and testbench
=================================

# player_hit_ctl

Player-side consumer of enemy missile coordinates and enemy alive flags. Scans every enemy missile against the player hitbox, decrements player lives on a hit, runs a frame-counted invulnerability window, and raises game-over and level-clear. Sits beside the player control/draw chain and takes the per-enemy missile position and alive outputs of all enemy instances.

## Interface
- N_EN, 4: number of enemy instances scanned.
- LIVES_INIT, 3: lives loaded at reset and restart, 1..7.
- PL_W, 64 / PL_H, 48: player hitbox size in pixels.
- MS_W, 4 / MS_H, 12: enemy missile hitbox size in pixels.
- INVULN_FRAMES, 120: invulnerability length in frame_tick pulses, 1..255.
- Y_OFF, 600: missile y at or above this is off-screen and ignored.

- pclk  in  1  pixel clock, the only clock.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on the pclk rising edge).
- frame_tick  in  1  one-cycle pulse per frame.
- restart  in  1  one-cycle pulse that reloads lives and leaves DEAD.
- level_change  in  1  one-cycle pulse at level transition.
- xpos_player, ypos_player  in  11 each  player top-left corner.
- en_x_missile, en_y_missile  in  11*N_EN each  packed missile top-left corners; enemy i occupies [11*i+10:11*i].
- en_alive  in  N_EN  per-enemy alive flags.
- lives  out  3  remaining lives.
- hit  out  1  one-cycle pulse per accepted hit.
- invuln  out  1  high during the invulnerability window.
- blink  out  1  high while the player sprite is visible (toggles every 8 frames during invuln, else 1).
- game_over  out  1  high in DEAD.
- level_clear  out  1  one-cycle pulse when en_alive goes from non-zero to all-zero.

## Operation
- Scan counter idx runs 0..N_EN-1 and wraps, one enemy per cycle, continuously.
- Candidate i: en_alive[i]=1, missile y < Y_OFF, and the rectangles overlap: mx < px+PL_W, px < mx+MS_W, my < py+PL_H, py < my+MS_H.
- Compute all sums in 12 bits so that nothing wraps at 2047.
- Compare result is registered (hit_q).
- FSM states:
  - ALIVE: hit_q=1 -> hit pulse, lives-1. If the new lives is 0, go to DEAD; otherwise go to INVULN with inv_cnt=INVULN_FRAMES.
  - INVULN: hit_q is ignored. inv_cnt decrements on frame_tick; when it reaches 0, go to ALIVE. blink toggles on every 8th frame_tick and is forced to 1 on exit.
  - DEAD: game_over=1, hit_q is ignored, lives=0. Exits only on restart.
- Priorities, evaluated in one cycle: rst > restart > level_change > hit_q.
  - restart: lives=LIVES_INIT, state ALIVE, inv_cnt=0, blink=1.
  - level_change outside DEAD: state ALIVE, inv_cnt=0, lives unchanged, a same-cycle hit_q is dropped.
  - level_change in DEAD: no effect.
- At most one decrement per hit event. Several overlapping missiles produce one hit because the FSM leaves ALIVE immediately.
- level_clear: en_alive_q != 0 and en_alive == 0, registered. No pulse during reset, restart, or level_change cycles. A level starting with all enemies dead produces no pulse.

## Timing
- Reset values: lives=LIVES_INIT, hit=0, invuln=0, blink=1, game_over=0, level_clear=0, state ALIVE, idx=0, hit_q=0, inv_cnt=0.
- Detection latency: overlap present at the scan of enemy i, giving hit_q on the next edge and hit/lives on the edge after. Worst case from overlap appearing to hit pulse is N_EN+1 cycles.
- All outputs are registered; lives, invuln, and game_over change on the same edge as hit.
- A rst assertion mid-INVULN or mid-scan returns everything to reset values on that edge.
- invuln rises with hit and falls on the edge where inv_cnt reaches 0, i.e. after INVULN_FRAMES frame_tick pulses.

## Structure
- Package player_pkg holds the FSM state enum (ALIVE, INVULN, DEAD), the 11-bit coordinate type, and the default geometry constants (PL_W, PL_H, MS_W, MS_H, Y_OFF) shared with the player draw and missile blocks.
- One sub-module, hit_box_cmp: a combinational 12-bit rectangle-overlap compare parameterised by both box sizes. It is reused by the player-missile-vs-enemy detector.

## Test plan
- Single hit: N_EN=4, player (400,500), en_alive=4'b0100, missile 2 at (420,510) -> within 6 cycles hit=1 for one cycle, lives 3->2, invuln=1.
- Invuln expiry: after that hit keep the missile overlapping and apply 120 frame_tick pulses -> no second hit during invuln. invuln drops after the 120th tick, then a second hit gives lives=1.
- Edge/ignore cases:
  - Missile at (464,500) with player at (400,500): touching, not overlapping -> no hit.
  - Overlapping missile of a dead enemy -> no hit.
  - Missile y=600 -> no hit.
- Death and restart: three hits -> lives=0, game_over=1, further overlaps give no hit. restart -> lives=3, game_over=0, state ALIVE.
- Simultaneous events: level_change in the same cycle as hit_q=1 -> lives unchanged, invuln=0. en_alive 4'b0001->4'b0000 -> level_clear pulses exactly once.
- Mid-operation reset: rst=0 during INVULN with inv_cnt=50 -> next edge lives=3, invuln=0, blink=1, all pulses low.

Source files
------------

// File: rtl/player_pkg.sv
// Shared player-side types and default geometry, also used by the player
// draw and missile blocks.
package player_pkg;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    typedef logic [10:0] coord_t;

    localparam int PL_W  = 64;
    localparam int PL_H  = 48;
    localparam int MS_W  = 4;
    localparam int MS_H  = 12;
    localparam int Y_OFF = 600;

endpackage

// File: rtl/hit_box_cmp.sv
// Combinational axis-aligned rectangle overlap test. Edge sums are 12 bits
// wide so boxes near x/y = 2047 never wrap around.
module hit_box_cmp
    import player_pkg::*;
#(
    parameter int A_W = 4,
    parameter int A_H = 12,
    parameter int B_W = 64,
    parameter int B_H = 48
) (
    input  coord_t i_ax,
    input  coord_t i_ay,
    input  coord_t i_bx,
    input  coord_t i_by,
    output logic   o_overlap
);

    logic [11:0] w_ax, w_ay, w_bx, w_by;
    logic [11:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

    assign w_ax     = {1'b0, i_ax};
    assign w_ay     = {1'b0, i_ay};
    assign w_bx     = {1'b0, i_bx};
    assign w_by     = {1'b0, i_by};
    assign w_ax_end = w_ax + 12'(A_W);
    assign w_ay_end = w_ay + 12'(A_H);
    assign w_bx_end = w_bx + 12'(B_W);
    assign w_by_end = w_by + 12'(B_H);

    // Strict compares: boxes that only share an edge do not overlap.
    assign o_overlap = (w_ax < w_bx_end) && (w_bx < w_ax_end) &&
                       (w_ay < w_by_end) && (w_by < w_ay_end);

endmodule

// File: rtl/player_hit_ctl.sv
// Scans enemy missiles one per cycle against the player hitbox and runs the
// lives / invulnerability / game-over state machine plus level-clear detect.
module player_hit_ctl #(
    parameter int N_EN          = 4,
    parameter int LIVES_INIT    = 3,
    parameter int PL_W          = player_pkg::PL_W,
    parameter int PL_H          = player_pkg::PL_H,
    parameter int MS_W          = player_pkg::MS_W,
    parameter int MS_H          = player_pkg::MS_H,
    parameter int INVULN_FRAMES = 120,
    parameter int Y_OFF         = player_pkg::Y_OFF
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                restart,
    input  logic                level_change,
    input  logic [10:0]         xpos_player,
    input  logic [10:0]         ypos_player,
    input  logic [11*N_EN-1:0]  en_x_missile,
    input  logic [11*N_EN-1:0]  en_y_missile,
    input  logic [N_EN-1:0]     en_alive,
    output logic [2:0]          lives,
    output logic                hit,
    output logic                invuln,
    output logic                blink,
    output logic                game_over,
    output logic                level_clear
);
    import player_pkg::*;

    localparam int IDX_W = (N_EN > 1) ? $clog2(N_EN) : 1;

    coord_t w_mx [N_EN];
    coord_t w_my [N_EN];

    generate
        for (genvar gi = 0; gi < N_EN; gi++) begin : g_unpack
            assign w_mx[gi] = en_x_missile[11*gi +: 11];
            assign w_my[gi] = en_y_missile[11*gi +: 11];
        end
    endgenerate

    logic [IDX_W-1:0] r_idx;
    logic             r_hit_q;
    state_t           r_state, w_state_next;
    logic [2:0]       r_lives, w_lives_next;
    logic [7:0]       r_inv_cnt, w_inv_next;
    logic [2:0]       r_bl_cnt, w_bl_cnt_next;
    logic             r_blink, w_blink_next;
    logic             w_hit_next;
    logic             r_hit, r_invuln, r_game_over, r_level_clear;
    logic [N_EN-1:0]  r_en_alive_q;
    logic             w_overlap, w_cand, w_level_clear_next;

    // A single comparator is time-shared across enemies by the scan index.
    hit_box_cmp #(
        .A_W(MS_W), .A_H(MS_H), .B_W(PL_W), .B_H(PL_H)
    ) u_cmp (
        .i_ax      (w_mx[r_idx]),
        .i_ay      (w_my[r_idx]),
        .i_bx      (xpos_player),
        .i_by      (ypos_player),
        .o_overlap (w_overlap)
    );

    assign w_cand = en_alive[r_idx] && (w_my[r_idx] < 11'(Y_OFF)) && w_overlap;
    assign w_level_clear_next = (r_en_alive_q != '0) && (en_alive == '0) &&
                                !restart && !level_change;

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_idx         <= '0;
            r_hit_q       <= 1'b0;
            r_state       <= ALIVE;
            r_lives       <= 3'(LIVES_INIT);
            r_inv_cnt     <= '0;
            r_bl_cnt      <= '0;
            r_blink       <= 1'b1;
            r_hit         <= 1'b0;
            r_invuln      <= 1'b0;
            r_game_over   <= 1'b0;
            r_en_alive_q  <= '0;
            r_level_clear <= 1'b0;
        end else begin
            r_idx         <= (r_idx == IDX_W'(N_EN - 1)) ? '0 : r_idx + 1'b1;
            r_hit_q       <= w_cand;
            r_state       <= w_state_next;
            r_lives       <= w_lives_next;
            r_inv_cnt     <= w_inv_next;
            r_bl_cnt      <= w_bl_cnt_next;
            r_blink       <= w_blink_next;
            r_hit         <= w_hit_next;
            r_invuln      <= (w_state_next == INVULN);
            r_game_over   <= (w_state_next == DEAD);
            r_en_alive_q  <= en_alive;
            r_level_clear <= w_level_clear_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (restart) begin
            w_state_next = ALIVE;
        end else if (level_change && r_state != DEAD) begin
            w_state_next = ALIVE;
        end else begin
            case (r_state)
                ALIVE:   if (r_hit_q) w_state_next = (r_lives <= 3'd1) ? DEAD : INVULN;
                INVULN:  if (frame_tick && r_inv_cnt <= 8'd1) w_state_next = ALIVE;
                DEAD:    w_state_next = DEAD;
                default: w_state_next = ALIVE;
            endcase
        end
    end

    always_comb begin
        w_lives_next  = r_lives;
        w_inv_next    = r_inv_cnt;
        w_bl_cnt_next = r_bl_cnt;
        w_blink_next  = r_blink;
        w_hit_next    = 1'b0;
        if (restart) begin
            w_lives_next  = 3'(LIVES_INIT);
            w_inv_next    = '0;
            w_bl_cnt_next = '0;
            w_blink_next  = 1'b1;
        end else if (level_change && r_state != DEAD) begin
            w_inv_next    = '0;
            w_bl_cnt_next = '0;
            w_blink_next  = 1'b1;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (r_hit_q) begin
                        w_hit_next    = 1'b1;
                        w_lives_next  = r_lives - 3'd1;
                        w_inv_next    = (r_lives <= 3'd1) ? 8'd0 : 8'(INVULN_FRAMES);
                        w_bl_cnt_next = '0;
                    end
                end
                INVULN: begin
                    if (frame_tick) begin
                        if (r_inv_cnt <= 8'd1) begin
                            w_inv_next    = '0;
                            w_bl_cnt_next = '0;
                            w_blink_next  = 1'b1;
                        end else begin
                            w_inv_next    = r_inv_cnt - 8'd1;
                            w_bl_cnt_next = r_bl_cnt + 3'd1;
                            if (r_bl_cnt == 3'd7) w_blink_next = ~r_blink;
                        end
                    end
                end
                DEAD:    w_lives_next = '0;
                default: w_lives_next = r_lives;
            endcase
        end
    end

    assign lives       = r_lives;
    assign hit         = r_hit;
    assign invuln      = r_invuln;
    assign blink       = r_blink;
    assign game_over   = r_game_over;
    assign level_clear = r_level_clear;

endmodule

// File: tb/tb_player_hit_ctl.sv
// Scenario bench for player_hit_ctl: expected hit outcomes are queued when the
// overlap is driven and checked when the hit pulse appears.
module tb_player_hit_ctl;

    localparam int N_EN = 4;

    logic              pclk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_tick = 1'b0;
    logic              restart = 1'b0;
    logic              level_change = 1'b0;
    logic [10:0]       xpos_player = 11'd400;
    logic [10:0]       ypos_player = 11'd500;
    logic [11*N_EN-1:0] en_x_missile = '0;
    logic [11*N_EN-1:0] en_y_missile = {N_EN{11'd700}};
    logic [N_EN-1:0]   en_alive = '0;
    logic [2:0]        lives;
    logic              hit, invuln, blink, game_over, level_clear;

    typedef struct {
        logic [2:0] lives;
        logic       invuln;
        logic       game_over;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    player_hit_ctl #(.N_EN(N_EN)) dut (
        .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
        .level_change(level_change), .xpos_player(xpos_player),
        .ypos_player(ypos_player), .en_x_missile(en_x_missile),
        .en_y_missile(en_y_missile), .en_alive(en_alive), .lives(lives),
        .hit(hit), .invuln(invuln), .blink(blink), .game_over(game_over),
        .level_clear(level_clear)
    );

    always #5 pclk = ~pclk;

    task automatic set_missile(input int i, input int x, input int y);
        en_x_missile[11*i +: 11] = 11'(x);
        en_y_missile[11*i +: 11] = 11'(y);
    endtask

    task automatic clear_missiles();
        for (int i = 0; i < N_EN; i++) set_missile(i, 0, 700);
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Wait for a hit pulse within budget cycles, then check the queued outcome.
    task automatic expect_hit(input string name, input int budget);
        exp_t e;
        bit   seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge pclk);
            if (hit === 1'b1) seen = 1;
        end
        e = exp_q.pop_front();
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: no hit within %0d cycles", name, budget);
        end else begin
            chk({name, "_lives"}, 8'(lives), 8'(e.lives));
            chk({name, "_invuln"}, 8'(invuln), 8'(e.invuln));
            chk({name, "_game_over"}, 8'(game_over), 8'(e.game_over));
            @(negedge pclk);
            chk({name, "_pulse_width"}, 8'(hit), 8'd0);
        end
        $display("txn %s: hit_seen=%0d lives=%0d invuln=%0d game_over=%0d", name, seen, lives, invuln, game_over);
    endtask

    task automatic count_hits(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge pclk);
            if (hit === 1'b1) n++;
        end
    endtask

    task automatic count_lc(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge pclk);
            if (level_clear === 1'b1) n++;
        end
    endtask

    task automatic pulse_level_change();
        @(negedge pclk); level_change = 1'b1;
        @(negedge pclk); level_change = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst_lives", 8'(lives), 8'd3);
        chk("rst_hit", 8'(hit), 8'd0);
        chk("rst_invuln", 8'(invuln), 8'd0);
        chk("rst_blink", 8'(blink), 8'd1);
        chk("rst_game_over", 8'(game_over), 8'd0);
        chk("rst_level_clear", 8'(level_clear), 8'd0);
        rst = 1'b1;
        $display("txn reset: lives=%0d blink=%0d", lives, blink);
    endtask

    task automatic test_single_hit();
        @(negedge pclk);
        xpos_player = 11'd400; ypos_player = 11'd500;
        en_alive = 4'b0100;
        set_missile(2, 420, 510);
        exp_q.push_back('{lives: 3'd2, invuln: 1'b1, game_over: 1'b0});
        expect_hit("single_hit", 6);
    endtask

    task automatic test_invuln_expiry();
        int nh = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge pclk); frame_tick = 1'b1;
            if (hit === 1'b1) nh++;
            @(negedge pclk); frame_tick = 1'b0;
            if (hit === 1'b1) nh++;
            if (i == 8)   chk("blink_toggle_8", 8'(blink), 8'd0);
            if (i == 16)  chk("blink_toggle_16", 8'(blink), 8'd1);
            if (i == 119) chk("invuln_before_last", 8'(invuln), 8'd1);
        end
        chk("invuln_fall", 8'(invuln), 8'd0);
        chk("blink_exit", 8'(blink), 8'd1);
        chk("hits_during_invuln", 8'(nh), 8'd0);
        $display("txn invuln_expiry: hits_during=%0d invuln=%0d", nh, invuln);
        exp_q.push_back('{lives: 3'd1, invuln: 1'b1, game_over: 1'b0});
        expect_hit("second_hit", 6);
        @(negedge pclk); clear_missiles();
        repeat (6) @(negedge pclk);
        pulse_level_change();
        chk("lc_exit_invuln", 8'(invuln), 8'd0);
        chk("lc_keeps_lives", 8'(lives), 8'd1);
    endtask

    task automatic test_ignore();
        int nh;
        @(negedge pclk); en_alive = 4'b0100; set_missile(2, 464, 500);
        count_hits(12, nh);
        chk("touch_no_hit", 8'(nh), 8'd0);
        $display("txn touching: hits=%0d", nh);
        @(negedge pclk); en_alive = 4'b1011; set_missile(2, 420, 510);
        count_hits(12, nh);
        chk("dead_enemy_no_hit", 8'(nh), 8'd0);
        $display("txn dead_enemy: hits=%0d", nh);
        @(negedge pclk); en_alive = 4'b0100; ypos_player = 11'd560; set_missile(2, 420, 600);
        count_hits(12, nh);
        chk("offscreen_no_hit", 8'(nh), 8'd0);
        $display("txn offscreen: hits=%0d", nh);
        @(negedge pclk); clear_missiles(); ypos_player = 11'd500;
        chk("ignore_lives", 8'(lives), 8'd1);
    endtask

    task automatic test_death_restart();
        int nh;
        @(negedge pclk); en_alive = 4'b0100; set_missile(2, 463, 500);
        exp_q.push_back('{lives: 3'd0, invuln: 1'b0, game_over: 1'b1});
        expect_hit("fatal_hit", 6);
        count_hits(20, nh);
        chk("dead_no_hit", 8'(nh), 8'd0);
        pulse_level_change();
        chk("dead_lc_game_over", 8'(game_over), 8'd1);
        chk("dead_lc_lives", 8'(lives), 8'd0);
        @(negedge pclk); clear_missiles();
        repeat (6) @(negedge pclk);
        restart = 1'b1;
        @(negedge pclk); restart = 1'b0;
        chk("restart_lives", 8'(lives), 8'd3);
        chk("restart_game_over", 8'(game_over), 8'd0);
        chk("restart_invuln", 8'(invuln), 8'd0);
        chk("restart_blink", 8'(blink), 8'd1);
        $display("txn restart: lives=%0d game_over=%0d", lives, game_over);
    endtask

    task automatic test_back_to_back();
        @(negedge pclk);
        en_alive = 4'b1111;
        for (int i = 0; i < N_EN; i++) set_missile(i, 420, 510);
        @(negedge pclk); level_change = 1'b1;
        @(negedge pclk); level_change = 1'b0;
        chk("lc_drop_hit", 8'(hit), 8'd0);
        chk("lc_drop_lives", 8'(lives), 8'd3);
        chk("lc_drop_invuln", 8'(invuln), 8'd0);
        $display("txn lc_vs_hit: lives=%0d invuln=%0d", lives, invuln);
        exp_q.push_back('{lives: 3'd2, invuln: 1'b1, game_over: 1'b0});
        expect_hit("hit_after_lc", 3);
    endtask

    task automatic test_mid_reset();
        @(negedge pclk); clear_missiles();
        for (int i = 0; i < 70; i++) begin
            @(negedge pclk); frame_tick = 1'b1;
            @(negedge pclk); frame_tick = 1'b0;
        end
        chk("mid_invuln", 8'(invuln), 8'd1);
        rst = 1'b0;
        @(negedge pclk); rst = 1'b1;
        chk("mr_lives", 8'(lives), 8'd3);
        chk("mr_invuln", 8'(invuln), 8'd0);
        chk("mr_blink", 8'(blink), 8'd1);
        chk("mr_hit", 8'(hit), 8'd0);
        chk("mr_game_over", 8'(game_over), 8'd0);
        chk("mr_level_clear", 8'(level_clear), 8'd0);
        $display("txn mid_reset: lives=%0d invuln=%0d", lives, invuln);
    endtask

    task automatic test_level_clear();
        int nl;
        @(negedge pclk); en_alive = 4'b0001;
        count_lc(3, nl);
        chk("lc_none_partial", 8'(nl), 8'd0);
        en_alive = 4'b0000;
        count_lc(8, nl);
        chk("level_clear_once", 8'(nl), 8'd1);
        $display("txn level_clear: pulses=%0d", nl);
        en_alive = 4'b0001;
        count_lc(3, nl);
        en_alive = 4'b0000; level_change = 1'b1;
        @(negedge pclk); level_change = 1'b0;
        nl = (level_clear === 1'b1) ? 1 : 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge pclk);
            if (level_clear === 1'b1) nl++;
        end
        chk("level_clear_suppressed", 8'(nl), 8'd0);
        chk("level_clear_lives", 8'(lives), 8'd3);
        $display("txn level_clear_on_lc: pulses=%0d", nl);
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_invuln_expiry();
        test_ignore();
        test_death_restart();
        test_back_to_back();
        test_mid_reset();
        test_level_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
